// File: rtl/onehot_pkg.sv
// Shared types and helpers for the one-hot decoder and its index FIFO.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package onehot_pkg;

    localparam int IDX_W = 3;
    localparam int WIDTH = 8;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    // Binary index to one-hot word.
    function automatic logic [WIDTH-1:0] idx2onehot(input idx_t idx);
        logic [WIDTH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Priority re-encoder: highest set bit wins, all-zero maps to 0.
    function automatic idx_t onehot2idx(input logic [WIDTH-1:0] v);
        idx_t r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) r = idx_t'(i);
        end
        return r;
    endfunction

    // True when exactly one bit is set.
    function automatic logic is_onehot(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/onehot_idx_fifo.sv
// Synchronous DEPTH x IDX_W index FIFO with push/pop/flush and occupancy.
// Latency: written entry is visible on rdata_o one edge after the push.
// Backpressure: full_o blocks pushes (no same-cycle bypass); flush wins over push/pop.
module onehot_idx_fifo
    import onehot_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  idx_t          wdata_i,
    input  logic          pop_i,
    output idx_t          rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    idx_t        mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign count_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    // Next pointer values; flush collapses both pointers to zero.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + 1'b1;
            if (do_pop)  rd_d = rd_q + 1'b1;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage array; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/onehot_decoder8.sv
// Buffered 3-to-8 decoder: each queued index drives a one-hot word for HOLD cycles, back to back.
// Latency: index pushed into an empty FIFO while idle appears on out one edge later.
// Backpressure: in_ready = !full from registered occupancy; clear drops the in-flight offer.
// Optional self-checker enabled by macro ONEHOT_DECODER_SELFCHECK_EN (err tied low otherwise).
module onehot_decoder8 #(
    parameter int HOLD  = 4,
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [onehot_pkg::IDX_W-1:0] in_idx,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         err
);
    import onehot_pkg::*;

    localparam int       AW       = $clog2(DEPTH);
    localparam bit [7:0] CNT_INIT = 8'(HOLD - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic             fifo_push;
    logic             fifo_pop;
    idx_t             fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_cnt;

    assign fifo_push = in_valid && !fifo_full && !clear;
    assign in_ready  = !fifo_full;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = out_valid_q || (fifo_cnt != '0);

    onehot_idx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (clear),
        .push_i  (fifo_push),
        .wdata_i (idx_t'(in_idx)),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // Sequencer: load a word from the FIFO, hold it, then chain the next one without a gap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        fifo_pop    = 1'b0;
        if (clear) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        out_d       = idx2onehot(fifo_rdata);
                        out_valid_d = 1'b1;
                        cnt_d       = CNT_INIT;
                        state_d     = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else if (!fifo_empty) begin
                        fifo_pop    = 1'b1;
                        out_d       = idx2onehot(fifo_rdata);
                        out_valid_d = 1'b1;
                        cnt_d       = CNT_INIT;
                    end else begin
                        out_d       = '0;
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    out_d       = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, hold counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef ONEHOT_DECODER_SELFCHECK_EN
    idx_t idx_q;
    logic err_q;
    logic bad;

    // Mismatch between the driven word and the index it was decoded from.
    assign bad = out_valid_q && ((onehot2idx(out_q) != idx_q) || !is_onehot(out_q));
    assign err = err_q;

    // Remember the popped index and latch any mismatch until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (fifo_pop) idx_q <= fifo_rdata;
            if (bad)      err_q <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_decoder8.sv
module tb_onehot_decoder8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [2:0] in_idx;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out;
    logic       out_valid;
    logic       busy;
    logic       err;

    logic       b_clear;
    logic [2:0] b_in_idx;
    logic       b_in_valid;
    logic       b_in_ready;
    logic [7:0] b_out;
    logic       b_out_valid;
    logic       b_busy;
    logic       b_err;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    onehot_decoder8 #(.HOLD(4), .DEPTH(4), .WIDTH(8)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_idx    (in_idx),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy),
        .err       (err)
    );

    onehot_decoder8 #(.HOLD(1), .DEPTH(4), .WIDTH(8)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (b_clear),
        .in_idx    (b_in_idx),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out       (b_out),
        .out_valid (b_out_valid),
        .busy      (b_busy),
        .err       (b_err)
    );

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] e;
        logic       acc;
        int         ni;
        int         seq [5];
        seq = '{1, 2, 3, 4, 6};

        rst_n      = 1'b0;
        clear      = 1'b0;
        in_idx     = 3'd0;
        in_valid   = 1'b0;
        b_clear    = 1'b0;
        b_in_idx   = 3'd0;
        b_in_valid = 1'b0;

        // Reset state
        #7;
        chk8("rst_out", out, 8'h00);
        chk1("rst_ovld", out_valid, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk1("rst_rdy", in_ready, 1'b1);
        chk8("rst_b_out", b_out, 8'h00);
        #5 rst_n = 1'b1;
        tick();

        // Single word, HOLD=4
        in_idx = 3'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk8("single_lat0", out, 8'h00);
        chk1("single_busy0", busy, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk8("single_out", out, 8'b0010_0000);
            chk1("single_ovld", out_valid, 1'b1);
        end
        tick();
        chk8("single_end_out", out, 8'h00);
        chk1("single_end_ovld", out_valid, 1'b0);
        chk1("single_end_busy", busy, 1'b0);

        // Reset asserted mid-hold
        in_idx = 3'd5; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk8("midrst_pre", out, 8'b0010_0000);
        #2 rst_n = 1'b0;
        #1;
        chk8("midrst_out", out, 8'h00);
        chk1("midrst_ovld", out_valid, 1'b0);
        chk1("midrst_rdy", in_ready, 1'b1);
        chk1("midrst_busy", busy, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk8("postrst_out", out, 8'h00);
            chk1("postrst_busy", busy, 1'b0);
        end

        // Back-to-back sweep 0..7
        ni = 0;
        for (int c = 0; c <= 33; c++) begin
            in_valid = (ni < 8);
            in_idx   = 3'(ni);
            acc      = in_valid && in_ready;
            tick();
            if (acc) ni++;
            e = 8'h00;
            if (c >= 1 && c <= 32) e = 8'd1 << ((c - 1) / 4);
            chk8("sweep_out", out, e);
            chk1("sweep_ovld", out_valid, (e != 8'h00));
            if (c == 4) chk1("sweep_rdy_full", in_ready, 1'b0);
            if (c == 5) chk1("sweep_rdy_free", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        chk1("sweep_idle_busy", busy, 1'b0);

        // Full boundary: extra offer of idx 7 while full is ignored
        for (int c = 0; c <= 21; c++) begin
            in_valid = (c <= 5);
            in_idx   = (c <= 4) ? 3'(seq[c]) : 3'd7;
            if (c == 5) chk1("full_rdy", in_ready, 1'b0);
            tick();
            e = 8'h00;
            if (c >= 1 && c <= 20) e = 8'd1 << seq[(c - 1) / 4];
            chk8("full_out", out, e);
            if (c == 5) chk1("full_rdy_after_pop", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        chk1("full_end_busy", busy, 1'b0);

        // clear during HOLD with three queued and an offer pending
        for (int c = 0; c < 4; c++) begin
            in_idx = 3'(c + 1); in_valid = 1'b1;
            tick();
        end
        chk8("clr_pre_out", out, 8'b0000_0010);
        in_idx = 3'd7; in_valid = 1'b1; clear = 1'b1;
        chk1("clr_pre_rdy", in_ready, 1'b1);
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk8("clr_out", out, 8'h00);
        chk1("clr_ovld", out_valid, 1'b0);
        chk1("clr_busy", busy, 1'b0);
        chk1("clr_rdy", in_ready, 1'b1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk8("clr_after_out", out, 8'h00);
        end
        chk1("a_err_final", err, 1'b0);

        // HOLD=1 exhaustive indices
        ni = 0;
        for (int c = 0; c <= 9; c++) begin
            b_in_valid = (ni < 8);
            b_in_idx   = 3'(ni);
            acc        = b_in_valid && b_in_ready;
            tick();
            if (acc) ni++;
            e = 8'h00;
            if (c >= 1 && c <= 8) e = 8'd1 << (c - 1);
            chk8("h1_out", b_out, e);
            chk1("h1_ovld", b_out_valid, (e != 8'h00));
        end
        b_in_valid = 1'b0;
        chk1("h1_err", b_err, 1'b0);

`ifdef ONEHOT_DECODER_SELFCHECK_EN
        // Corrupt the driven word and expect the sticky error
        b_in_idx = 3'd2; b_in_valid = 1'b1;
        tick();
        b_in_valid = 1'b0;
        tick();
        chk8("sc_out", b_out, 8'b0000_0100);
        force u_b.out_q = 8'b0000_0110;
        tick();
        release u_b.out_q;
        chk1("sc_err_set", b_err, 1'b1);
        tick();
        tick();
        chk1("sc_err_sticky", b_err, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/onehot_decoder8.md
Name: onehot_decoder8

Overview:
Sequential 3-to-8 decoder, the inverse of the team's 8-input priority encoder. Accepts a stream of binary indices over a valid/ready handshake and buffers them in a small FIFO. Emits each index as a one-hot 8-bit strobe held for HOLD cycles, back to back. Drives one-hot select/enable lines (LED banks, mux selects) from encoded sources such as the priority encoder output.

Parameters:
HOLD, 4, cycles each one-hot word stays asserted; legal range 1..255
DEPTH, 4, index FIFO entries; power of 2, minimum 2
WIDTH, 8, one-hot output width; fixed at 8 in this revision (IDX_W = 3 derived)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of FIFO and output
in_idx  input  3  index to decode
in_valid  input  1  in_idx is valid
in_ready  output  1  FIFO can accept; equals !full
out  output  8  one-hot strobe, registered; all-zero when idle
out_valid  output  1  out holds a decoded word
busy  output  1  out_valid OR FIFO non-empty
err  output  1  self-check failure, sticky (see Optional Feature)

Behaviour:
- Reset: one clock, asynchronous, active-low. rst_n low forces out=0, out_valid=0, busy=0, err=0, FIFO empty, in_ready=1, state IDLE, hold counter 0. Reset takes effect immediately, including mid-hold.
- Push: an index is written on a rising edge with in_valid && in_ready. in_ready derives from registered occupancy only. There is no bypass: when full, in_ready=0 even if a pop occurs in the same cycle.
- States:
  - IDLE: if FIFO non-empty, pop; out <= 1<<idx; out_valid <= 1; cnt <= HOLD-1; go to HOLD.
  - HOLD: if cnt != 0, decrement. If cnt == 0 and FIFO non-empty, pop and load the next word in the same edge (no gap cycle), cnt <= HOLD-1. If cnt == 0 and FIFO empty, out <= 0, out_valid <= 0, go to IDLE.
- Latency: an index pushed at edge N into an empty FIFO while IDLE appears on out after edge N+1.
- HOLD=1: each word lasts exactly one cycle, and a full FIFO drains one word per cycle.
- Push and pop in the same edge: allowed when not full; occupancy is unchanged.
- clear: has priority over push and pop. At the next edge the FIFO empties, out=0, out_valid=0, state goes to IDLE. An in_valid in that cycle is dropped even if in_ready=1. err is not cleared.
- Invariant: out is always all-zero or exactly one-hot; out != 0 iff out_valid.
- Pointer wrap: modulo DEPTH, with an extra occupancy bit to distinguish full from empty.

Optional Feature:
Macro ONEHOT_DECODER_SELFCHECK_EN.
- Defined: instantiates an 8-to-3 priority re-encoder on the registered out. When out_valid=1 and the re-encoded index differs from the stored popped index, or out is not one-hot, err is set on the next edge and stays set until rst_n.
- Undefined: no checker logic; err tied to 0. The port is present in both builds.

Decomposition:
- Shared package onehot_pkg:
  - IDX_W=3, WIDTH=8 constants
  - state typedef {IDLE, HOLD}
  - idx_t (3-bit) typedef
  - function idx2onehot
- Natural sub-module: onehot_idx_fifo. Synchronous DEPTH x 3 FIFO with push/pop/flush, full/empty, occupancy.

Test Plan:
- Reset mid-hold: push idx 5, drop rst_n while out=8'b00100000 -> out=0, out_valid=0, in_ready=1 immediately; no output after release.
- Single word, HOLD=4: push idx 5 at edge N -> out=8'b00100000 after edges N+1..N+4, then 0 after N+5; busy falls with out_valid.
- Back-to-back sweep: push 0..7 continuously, DEPTH=4 -> in_ready drops after the 4th queued entry. out walks 00000001..10000000 with no zero cycle between words, each word 4 cycles; 32 cycles total.
- Full boundary: fill FIFO while holding a word -> in_ready=0, the extra in_valid is ignored; a pop frees one slot and in_ready=1 next cycle.
- clear during HOLD with 3 queued and in_valid=1 -> next edge out=0, FIFO empty; the offered index is never emitted.
- HOLD=1, exhaustive indices 0..7 -> out equals 1<<idx for exactly one cycle each. With ONEHOT_DECODER_SELFCHECK_EN defined, err stays 0; a forced corrupt out bit sets err.
